// File: rtl/pipe_exc_ctrl.sv
// pipe_exc_ctrl -- exception and interrupt controller for the pipelined CPU.
// Chooses the IF-stage PC source (npc / EPC / exception base), owns the CP0
// Status, Cause and EPC registers, runs the interrupt handshake and cancels
// the instructions that a redirect kills.
// Optional feature: define EXC_OVF_EN to build the EXE-stage overflow source
// (Status/Cause handling for ovf and the cancel_exe output).
`timescale 1ns/1ps
module pipe_exc_ctrl #(
  parameter logic [31:0] EXC_BASE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        intr,
  output logic        inta,
  input  logic [31:0] pc_id,
  input  logic [31:0] pc_exe,
  input  logic        bd_id,
  input  logic        bd_exe,
  input  logic        sys_id,
  input  logic        unimpl_id,
  input  logic        eret_id,
  input  logic        ovf_exe,
  input  logic        mtc0_id,
  input  logic [4:0]  c0_waddr,
  input  logic [31:0] c0_wdata,
  input  logic [4:0]  c0_raddr,
  output logic [31:0] c0_rdata,
  output logic [1:0]  selpc,
  output logic [31:0] epc,
  output logic        cancel_id,
  output logic        cancel_exe
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [4:0] CODE_INT    = 5'd0;
  localparam logic [4:0] CODE_SYS    = 5'd8;
  localparam logic [4:0] CODE_UNIMPL = 5'd10;
  localparam logic [4:0] CODE_OVF    = 5'd12;

  localparam logic [1:0] SEL_NPC  = 2'b00;
  localparam logic [1:0] SEL_EPC  = 2'b01;
  localparam logic [1:0] SEL_BASE = 2'b10;

  // Without the overflow source, the ovf enable bit of every nibble is absent.
`ifdef EXC_OVF_EN
  localparam logic [11:0] STATUS_MASK = 12'hFFF;
`else
  localparam logic [11:0] STATUS_MASK = 12'h777;
`endif

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t      state;
  logic [11:0] status;
  logic [31:0] cause;

  logic        req_ovf;
  logic        req_unimpl;
  logic        req_sys;
  logic        req_int;
  logic        any_req;
  logic        in_run;
  logic        take;
  logic        do_eret;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_pc;
  logic [31:0] exc_epc;

  // The handler base lives in the IF stage; the overflow inputs are only
  // consumed when that source is built.
  logic unused_inputs;
`ifdef EXC_OVF_EN
  assign unused_inputs = ^EXC_BASE;
`else
  assign unused_inputs = ^{EXC_BASE, ovf_exe, pc_exe, bd_exe};
`endif

  // Gate every source with its current enable and resolve priority.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    req_ovf    = 1'b0;
`ifdef EXC_OVF_EN
    req_ovf    = ovf_exe & status[3];
`endif
    req_unimpl = unimpl_id & status[2];
    req_sys    = sys_id    & status[1];
    req_int    = intr      & status[0];
    any_req    = req_ovf | req_unimpl | req_sys | req_int;

    exc_code   = CODE_INT;
    exc_bd     = bd_id;
    exc_pc     = pc_id;
`ifdef EXC_OVF_EN
    if (req_ovf) begin
      exc_code = CODE_OVF;
      exc_bd   = bd_exe;
      exc_pc   = pc_exe;
    end else
`endif
    if (req_unimpl) begin
      exc_code = CODE_UNIMPL;
    end else if (req_sys) begin
      exc_code = CODE_SYS;
    end

    // A delay-slot instruction restarts at its branch.
    exc_epc    = exc_bd ? (exc_pc - 32'd4) : exc_pc;
  end

  assign in_run  = (state == ST_RUN);
  assign take    = in_run & any_req;
  assign do_eret = in_run & ~any_req & eret_id;

  // PC source: redirect beats eret; REDIR falls through to the normal npc.
  always_comb begin
    selpc = SEL_NPC;
    if (take) begin
      selpc = SEL_BASE;
    end else if (do_eret) begin
      selpc = SEL_EPC;
    end
  end

  // In REDIR the slot fetched before the redirect is killed as well.
  assign cancel_id = take | ~in_run;

`ifdef EXC_OVF_EN
  assign cancel_exe = take & req_ovf;
`else
  assign cancel_exe = 1'b0;
`endif

  // The acknowledge only fires when the interrupt is the winning source and
  // the acceptance actually commits.
  assign inta = take & ~stall & req_int & ~req_sys & ~req_unimpl & ~req_ovf;

  // mfc0 read port.
  always_comb begin
    c0_rdata = 32'd0;
    case (c0_raddr)
      ADDR_STATUS: c0_rdata = {20'd0, status};
      ADDR_CAUSE:  c0_rdata = cause;
      ADDR_EPC:    c0_rdata = epc;
      default:     c0_rdata = 32'd0;
    endcase
  end

  // FSM and CP0 registers; nothing commits while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state  <= ST_RUN;
      status <= 12'd0;
      cause  <= 32'd0;
      epc    <= 32'd0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (take) begin
            state  <= ST_REDIR;
            epc    <= exc_epc;
            cause  <= {exc_bd, 24'd0, exc_code, 2'b00};
            status <= (status << 4) & STATUS_MASK;
          end else if (do_eret) begin
            status <= {4'd0, status[11:4]};
          end else if (mtc0_id) begin
            case (c0_waddr)
              ADDR_STATUS: status <= c0_wdata[11:0] & STATUS_MASK;
              ADDR_CAUSE:  cause  <= c0_wdata;
              ADDR_EPC:    epc    <= c0_wdata;
              default:     ;
            endcase
          end
        end
        ST_REDIR: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_exc_ctrl.sv
// tb_pipe_exc_ctrl -- self-checking bench for pipe_exc_ctrl: a directed
// vector table, hand-written corner sequences (overflow priority, async reset
// during REDIR) and a random phase compared against a behavioural model.
`timescale 1ns/1ps
module tb_pipe_exc_ctrl;

`ifdef EXC_OVF_EN
  localparam bit OVF_BUILT = 1'b1;
`else
  localparam bit OVF_BUILT = 1'b0;
`endif
  localparam logic [11:0] SMASK = OVF_BUILT ? 12'hFFF : 12'h777;
  localparam logic [31:0] S_F   = OVF_BUILT ? 32'h0F : 32'h07;
  localparam logic [31:0] S_F0  = OVF_BUILT ? 32'hF0 : 32'h70;
  // ovf + unimpl together: ovf wins when built, unimpl otherwise.
  localparam logic [31:0] A_EPC   = OVF_BUILT ? 32'h20 : 32'h24;
  localparam logic [31:0] A_CAUSE = OVF_BUILT ? 32'h30 : 32'h28;
  localparam logic        A_CEX   = OVF_BUILT;
  // Exception codes indexed by enable-bit position: int, sys, unimpl, ovf.
  localparam int EXC_CODE [4] = '{0, 8, 10, 12};

  typedef struct packed {
    logic        stall, intr, sys, unimpl, eret, ovf, mtc0, bd_id, bd_exe;
    logic [31:0] pc_id, pc_exe;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata;
  } vin_t;

  typedef struct packed {
    logic [1:0]  selpc;
    logic        cid, cex, inta;
    logic [31:0] epc, rdata;
  } exp_t;

  typedef struct packed {
    vin_t in;
    exp_t ex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 0, intr = 0, bd_id = 0, bd_exe = 0;
  logic        sys_id = 0, unimpl_id = 0, eret_id = 0, ovf_exe = 0, mtc0_id = 0;
  logic [31:0] pc_id = 0, pc_exe = 0, c0_wdata = 0;
  logic [4:0]  c0_waddr = 0, c0_raddr = 0;
  logic        inta, cancel_id, cancel_exe;
  logic [1:0]  selpc;
  logic [31:0] epc, c0_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  // Behavioural model state.
  logic [11:0] m_status;
  logic [31:0] m_cause, m_epc;
  bit          m_redir;

  pipe_exc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .intr(intr), .inta(inta),
    .pc_id(pc_id), .pc_exe(pc_exe), .bd_id(bd_id), .bd_exe(bd_exe),
    .sys_id(sys_id), .unimpl_id(unimpl_id), .eret_id(eret_id),
    .ovf_exe(ovf_exe), .mtc0_id(mtc0_id), .c0_waddr(c0_waddr),
    .c0_wdata(c0_wdata), .c0_raddr(c0_raddr), .c0_rdata(c0_rdata),
    .selpc(selpc), .epc(epc), .cancel_id(cancel_id), .cancel_exe(cancel_exe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vin_t vi(input logic [4:0] ra);
    vin_t v;
    v = '0;
    v.raddr = ra;
    return v;
  endfunction

  task automatic add(input vin_t v, input logic [1:0] sp, input logic cid, input logic cex,
                     input logic ia, input logic [31:0] ep, input logic [31:0] rd);
    vec_t r;
    r.in = v;
    r.ex = '{selpc: sp, cid: cid, cex: cex, inta: ia, epc: ep, rdata: rd};
    tbl.push_back(r);
  endtask

  task automatic drive(input vin_t v);
    stall = v.stall; intr = v.intr; sys_id = v.sys; unimpl_id = v.unimpl;
    eret_id = v.eret; ovf_exe = v.ovf; mtc0_id = v.mtc0; bd_id = v.bd_id;
    bd_exe = v.bd_exe; pc_id = v.pc_id; pc_exe = v.pc_exe;
    c0_waddr = v.waddr; c0_raddr = v.raddr; c0_wdata = v.wdata;
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".selpc"},      {30'd0, selpc},      {30'd0, e.selpc});
    check({tag, ".cancel_id"},  {31'd0, cancel_id},  {31'd0, e.cid});
    check({tag, ".cancel_exe"}, {31'd0, cancel_exe}, {31'd0, e.cex});
    check({tag, ".inta"},       {31'd0, inta},       {31'd0, e.inta});
    check({tag, ".epc"},        epc,                 e.epc);
    check({tag, ".c0_rdata"},   c0_rdata,            e.rdata);
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then cross the clock edge.
  task automatic apply(input vin_t v, input exp_t e, input string tag);
    drive(v);
    #1;
    check_outs(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic hand(input vin_t v, input logic [1:0] sp, input logic cid, input logic cex,
                      input logic ia, input logic [31:0] ep, input logic [31:0] rd,
                      input string tag);
    exp_t e;
    e = '{selpc: sp, cid: cid, cex: cex, inta: ia, epc: ep, rdata: rd};
    apply(v, e, tag);
  endtask

  // ---------------- behavioural reference model ----------------
  // Highest-priority enabled source, as an enable-bit index, or -1.
  function automatic int winner(input vin_t v);
    logic [3:0] raised;
    raised = {v.ovf & OVF_BUILT, v.unimpl, v.sys, v.intr};
    for (int k = 3; k >= 0; k--)
      if (raised[k] && m_status[k]) return k;
    return -1;
  endfunction

  function automatic exp_t model_out(input vin_t v);
    exp_t e;
    int   w;
    e = '0;
    w = winner(v);
    e.epc = m_epc;
    if (v.raddr == 5'd12)      e.rdata = {20'd0, m_status};
    else if (v.raddr == 5'd13) e.rdata = m_cause;
    else if (v.raddr == 5'd14) e.rdata = m_epc;
    if (m_redir) begin
      e.cid = 1'b1;
    end else if (w >= 0) begin
      e.selpc = 2'd2;
      e.cid   = 1'b1;
      e.cex   = (w == 3);
      e.inta  = (w == 0) && !v.stall;
    end else if (v.eret) begin
      e.selpc = 2'd1;
    end
    return e;
  endfunction

  task automatic model_step(input vin_t v);
    int          w;
    logic [31:0] src;
    logic        bd;
    if (v.stall) return;
    w = winner(v);
    if (m_redir) begin
      m_redir = 1'b0;
    end else if (w >= 0) begin
      src      = (w == 3) ? v.pc_exe : v.pc_id;
      bd       = (w == 3) ? v.bd_exe : v.bd_id;
      m_epc    = bd ? src - 32'd4 : src;
      m_cause  = (bd ? 32'h8000_0000 : 32'h0) + 32'(EXC_CODE[w] * 4);
      m_status = 12'(m_status * 16) & SMASK;
      m_redir  = 1'b1;
    end else if (v.eret) begin
      m_status = m_status / 16;
    end else if (v.mtc0) begin
      if (v.waddr == 5'd12)      m_status = v.wdata[11:0] & SMASK;
      else if (v.waddr == 5'd13) m_cause  = v.wdata;
      else if (v.waddr == 5'd14) m_epc    = v.wdata;
    end
  endtask

  initial begin
    vin_t v;
    exp_t e;
    int   r;

    // ---------------- vector table ----------------
    v = vi(12);                                                add(v, 2'd0, 0, 0, 0, 32'h0,   32'h0);
    v = vi(12); v.mtc0 = 1; v.waddr = 12; v.wdata = 32'hF;     add(v, 2'd0, 0, 0, 0, 32'h0,   32'h0);
    v = vi(12);                                                add(v, 2'd0, 0, 0, 0, 32'h0,   S_F);
    v = vi(12); v.intr = 1; v.pc_id = 32'h40;                  add(v, 2'd2, 1, 0, 1, 32'h0,   S_F);
    v = vi(14);                                                add(v, 2'd0, 1, 0, 0, 32'h40,  32'h40);
    v = vi(12);                                                add(v, 2'd0, 0, 0, 0, 32'h40,  S_F0);
    v = vi(13);                                                add(v, 2'd0, 0, 0, 0, 32'h40,  32'h0);
    v = vi(12); v.eret = 1;                                    add(v, 2'd1, 0, 0, 0, 32'h40,  S_F0);
    v = vi(12);                                                add(v, 2'd0, 0, 0, 0, 32'h40,  S_F);
    v = vi(13); v.sys = 1; v.bd_id = 1; v.pc_id = 32'h104;     add(v, 2'd2, 1, 0, 0, 32'h40,  32'h0);
    v = vi(13); v.intr = 1;                                    add(v, 2'd0, 1, 0, 0, 32'h100, 32'h8000_0020);
    v = vi(12); v.eret = 1;                                    add(v, 2'd1, 0, 0, 0, 32'h100, S_F0);
    v = vi(14); v.intr = 1; v.pc_id = 32'h200;                 add(v, 2'd2, 1, 0, 1, 32'h100, 32'h100);
    v = vi(13); v.intr = 1; v.mtc0 = 1; v.waddr = 12; v.wdata = 32'hF;
                                                               add(v, 2'd0, 1, 0, 0, 32'h200, 32'h0);
    v = vi(12); v.intr = 1;                                    add(v, 2'd0, 0, 0, 0, 32'h200, S_F0);
    v = vi(12); v.intr = 1; v.mtc0 = 1; v.waddr = 12; v.wdata = 32'hF;
                                                               add(v, 2'd0, 0, 0, 0, 32'h200, S_F0);
    v = vi(12); v.intr = 1; v.stall = 1; v.pc_id = 32'h300;    add(v, 2'd2, 1, 0, 0, 32'h200, S_F);
    v = vi(14); v.intr = 1; v.stall = 1; v.pc_id = 32'h300;    add(v, 2'd2, 1, 0, 0, 32'h200, 32'h200);
    v = vi(12); v.intr = 1; v.pc_id = 32'h300;                 add(v, 2'd2, 1, 0, 1, 32'h200, S_F);
    v = vi(14);                                                add(v, 2'd0, 1, 0, 0, 32'h300, 32'h300);
    v = vi(13); v.mtc0 = 1; v.waddr = 13; v.wdata = 32'h1234_5678;
                                                               add(v, 2'd0, 0, 0, 0, 32'h300, 32'h0);
    v = vi(13);                                                add(v, 2'd0, 0, 0, 0, 32'h300, 32'h1234_5678);
    v = vi(5);  v.mtc0 = 1; v.waddr = 14; v.wdata = 32'hABC;   add(v, 2'd0, 0, 0, 0, 32'h300, 32'h0);
    v = vi(14);                                                add(v, 2'd0, 0, 0, 0, 32'hABC, 32'hABC);
    v = vi(12); v.unimpl = 1; v.pc_id = 32'h500;               add(v, 2'd0, 0, 0, 0, 32'hABC, S_F0);

    // ---------------- reset state ----------------
    drive(vi(12));
    #1;
    check_outs("reset", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i].in, tbl[i].ex, $sformatf("vec%0d", i));

    // ---------------- overflow versus unimplemented in the same cycle ----------------
    v = vi(12); v.mtc0 = 1; v.waddr = 12; v.wdata = 32'hF;
    hand(v, 2'd0, 0, 0, 0, 32'hABC, S_F0, "ovf_setup");
    v = vi(13); v.ovf = 1; v.pc_exe = 32'h20; v.unimpl = 1; v.pc_id = 32'h24;
    hand(v, 2'd2, 1, A_CEX, 0, 32'hABC, 32'h1234_5678, "ovf_take");
    v = vi(13);
    hand(v, 2'd0, 1, 0, 0, A_EPC, A_CAUSE, "ovf_redir");
    v = vi(12); v.eret = 1;
    hand(v, 2'd1, 0, 0, 0, A_EPC, S_F0, "ovf_eret");
    v = vi(12);
    hand(v, 2'd0, 0, 0, 0, A_EPC, S_F, "ovf_after");

    // ---------------- asynchronous reset in the middle of REDIR ----------------
    v = vi(12); v.intr = 1; v.pc_id = 32'h80;
    hand(v, 2'd2, 1, 0, 1, A_EPC, S_F, "arst_take");
    drive(vi(14));
    #1;
    check("arst_pre.cancel_id", {31'd0, cancel_id}, 32'd1);
    check("arst_pre.epc", epc, 32'h80);
    rst = 1'b1;
    #2;
    check("arst.cancel_id", {31'd0, cancel_id}, 32'd0);
    check("arst.epc", epc, 32'h0);
    c0_raddr = 5'd12;
    #1;
    check("arst.status", c0_rdata, 32'h0);
    check("arst.selpc", {30'd0, selpc}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- randomized run against the model ----------------
    m_status = '0;
    m_cause  = '0;
    m_epc    = '0;
    m_redir  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.stall  = ($urandom_range(0, 4) == 0);
      v.intr   = ($urandom_range(0, 2) == 0);
      v.sys    = ($urandom_range(0, 5) == 0);
      v.unimpl = ($urandom_range(0, 5) == 0);
      v.ovf    = ($urandom_range(0, 5) == 0);
      v.eret   = ($urandom_range(0, 4) == 0);
      v.mtc0   = !v.eret && ($urandom_range(0, 2) == 0);
      v.bd_id  = 1'($urandom_range(0, 1));
      v.bd_exe = 1'($urandom_range(0, 1));
      v.pc_id  = $urandom & 32'hFFFF_FFFC;
      v.pc_exe = $urandom & 32'hFFFF_FFFC;
      r = $urandom_range(0, 3);
      v.waddr  = (r == 3) ? 5'($urandom_range(0, 31)) : 5'(12 + r);
      r = $urandom_range(0, 3);
      v.raddr  = (r == 3) ? 5'($urandom_range(0, 31)) : 5'(12 + r);
      v.wdata  = $urandom;
      e = model_out(v);
      apply(v, e, $sformatf("rnd%0d", n));
      model_step(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_exc_ctrl.md
# pipe_exc_ctrl

Exception and interrupt controller for the interrupt-capable pipelined CPU. Every cycle it decides whether the IF stage fetches the normal next PC, returns to EPC on `eret`, or redirects to the exception base. It also holds the CP0 Status, Cause and EPC registers, runs the external-interrupt handshake, and cancels the instructions killed by a redirect. It sits beside the ID/EXE control unit and drives the IF stage's `selpc` and `epc` inputs.

## Interface
- `EXC_BASE`, default 32'h0000_0008: handler entry address; informational only, because the IF stage holds its own copy.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: pipeline stall. While high, no CP0 register or FSM update occurs, and `inta` stays low.
- `intr` input 1: level interrupt request. Must be held until `inta`.
- `inta` output 1: one-cycle interrupt acknowledge.
- `pc_id`, `pc_exe` input 32: PCs of the ID and EXE instructions.
- `bd_id`, `bd_exe` input 1: the instruction in that stage sits in a branch delay slot.
- `sys_id`, `unimpl_id`, `eret_id` input 1: ID decode flags for syscall, unimplemented opcode and eret.
- `ovf_exe` input 1: arithmetic overflow in EXE, qualified by the trapping-opcode check.
- `mtc0_id` input 1: mtc0 in ID.
- `c0_waddr` input 5: CP0 write address. 12 = Status, 13 = Cause, 14 = EPC.
- `c0_wdata` input 32: CP0 write data.
- `c0_raddr` input 5: CP0 read address for mfc0.
- `c0_rdata` output 32: combinational read data. Returns 0 for any other address.
- `selpc` output 2: 00 = npc, 01 = epc, 10 = exception base.
- `epc` output 32: EPC register.
- `cancel_id`, `cancel_exe` output 1: turn the instruction in that stage into a no-op.

## Operation
- Status (12 bits) is a 3-deep stack of enable nibbles. Bits [3:0] are the current enables, ordered {ovf, unimpl, sys, int}.
- Each exception source is gated by its enable bit: `req_ovf`, `req_unimpl`, `req_sys`, `req_int`.
- Priority, highest first:
  - overflow in EXE;
  - unimplemented opcode in ID;
  - syscall in ID;
  - interrupt, taken at the ID instruction.
- ExcCode written to Cause[6:2]: int 0, sys 8, unimpl 10, ovf 12.
- EPC value:
  - ovf: `pc_exe`, or `pc_exe - 4` when `bd_exe`.
  - Other causes: `pc_id`, or `pc_id - 4` when `bd_id`.
  - Cause[31] is set to the matching bd flag.
- On acceptance (FSM in RUN, `stall` low, some request active):
  - `selpc` = 10 in the same cycle, combinationally.
  - `cancel_id` = 1. `cancel_exe` = 1 only for ovf.
  - At the clock edge: EPC and Cause are written, and Status <= Status << 4.
  - For int: `inta` = 1 for that one cycle.
- `eret_id` in RUN with no request and `stall` low:
  - `selpc` = 01.
  - At the clock edge: Status <= {4'b0, Status[11:4]}.
- mtc0: the write happens at the clock edge when `mtc0_id` is high, `stall` is low and nothing is cancelling ID. An exception accepted in the same cycle wins, and the mtc0 is dropped.
- FSM states:
  - RUN -> REDIR on acceptance.
  - REDIR -> RUN after exactly one non-stalled cycle.
  - In REDIR, `cancel_id` = 1 (the slot fetched before the redirect is killed), all requests are ignored, `selpc` = 00, and eret/mtc0 are suppressed.
- With `stall` high, outputs are still driven combinationally, but they do not commit: no state or register change, and `inta` stays 0.
- Reset: Status = 0, Cause = 0, EPC = 0, FSM = RUN, `inta` = 0, `selpc` = 00, `cancel_*` = 0.

## Timing
- Redirect latency is 0 cycles: `selpc` reacts in the detection cycle, so the next PC is the base address.
- CP0 updates are visible on `c0_rdata` and `epc` one cycle after acceptance.
- Back-to-back exceptions: the earliest one accepted is in the cycle after REDIR.
- `rst` asserted mid-REDIR forces RUN immediately, independent of `clk`.
- If `intr` drops before `inta`, no interrupt is taken. No latching occurs.

## Configuration
- `EXC_OVF_EN` defined: the overflow source, Status/Cause bit handling for ovf, and `cancel_exe` are implemented.
- Undefined:
  - `ovf_exe` is ignored.
  - `cancel_exe` is tied to 0.
  - Status bit 3 of each nibble reads 0 and ignores writes.
  - EPC never selects `pc_exe`.

## Test plan
- Reset, then mtc0 Status = 0xF, then `intr` = 1 with `pc_id` = 0x40 -> `selpc` = 10 and `inta` pulse in the same cycle; next cycle EPC = 0x40, Cause = 0x00, Status = 0xF0.
- `sys_id` with `bd_id` = 1 and `pc_id` = 0x104, Status = 0xF -> EPC = 0x100, Cause = 0x8000_0020.
- `ovf_exe` (`pc_exe` = 0x20) together with `unimpl_id` (`pc_id` = 0x24) -> ovf wins: EPC = 0x20, Cause[6:2] = 12, `cancel_id` = `cancel_exe` = 1.
- After an exception, `eret_id` -> `selpc` = 01; Status returns to 0xF next cycle.
- Request arrives while `stall` = 1 -> no register change and `inta` = 0; the request is accepted in the first cycle after `stall` = 0.
- `intr` held with Status[0] = 0 -> never acknowledged. A request in the REDIR cycle is ignored, then taken in the following cycle.
